// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer: prioritises execute-stage exceptions, drives the CP0 write
// port through the EPC/Cause and SR updates, and redirects the PC on exception entry or ERET.
module exc_sequencer #(
  parameter logic [31:0] HANDLER_VEC = 32'h0000_0080,
  parameter int unsigned INT_W       = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [INT_W-1:0] IntReq,
  input  logic             Syscall,
  input  logic             RI,
  input  logic             Overflow,
  input  logic             EretReq,
  input  logic [31:0]      ExcPC,
  input  logic [31:0]      SrIn,
  input  logic [31:0]      EpcIn,
  output logic [31:0]      CP0DataIn,
  output logic [4:0]       CP0RegIdx,
  output logic             CP0Write,
  output logic             Exception,
  output logic [4:0]       Cause,
  output logic             PCRedirect,
  output logic [31:0]      RedirectPC,
  output logic             Stall
);

  localparam logic [4:0] CodeInt  = 5'd0;
  localparam logic [4:0] CodeSys  = 5'd8;
  localparam logic [4:0] CodeRi   = 5'd10;
  localparam logic [4:0] CodeOv   = 5'd12;
  localparam logic [4:0] RegSr    = 5'd12;
  localparam logic [4:0] RegEpc   = 5'd14;

  typedef enum logic [2:0] {
    StIdle,
    StExcEpc,
    StExcSr,
    StExcJmp,
    StEretSr,
    StEretJmp
  } state_e;

  state_e     state_q;
  logic       int_valid;
  logic       exc_valid;
  logic [4:0] exc_code;
  logic       accept;

  always_comb begin
    int_valid = (|IntReq) & SrIn[0] & ~SrIn[1];
    exc_valid = int_valid | RI | Overflow | Syscall;
    exc_code  = CodeSys;
    if (int_valid)     exc_code = CodeInt;
    else if (RI)       exc_code = CodeRi;
    else if (Overflow) exc_code = CodeOv;
    accept = exc_valid | EretReq;
    Stall  = (state_q != StIdle) | accept;
  end

  // Output registers double as the latched code/PC, so later input changes cannot leak in.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StIdle;
      CP0DataIn  <= '0;
      CP0RegIdx  <= '0;
      CP0Write   <= 1'b0;
      Exception  <= 1'b0;
      Cause      <= '0;
      PCRedirect <= 1'b0;
      RedirectPC <= '0;
    end else begin
      CP0Write   <= 1'b0;
      Exception  <= 1'b0;
      PCRedirect <= 1'b0;
      case (state_q)
        StIdle: begin
          if (exc_valid) begin
            state_q   <= StExcEpc;
            CP0Write  <= 1'b1;
            Exception <= 1'b1;
            CP0RegIdx <= RegEpc;
            CP0DataIn <= ExcPC;
            Cause     <= exc_code;
          end else if (EretReq) begin
            state_q   <= StEretSr;
            CP0Write  <= 1'b1;
            CP0RegIdx <= RegSr;
            CP0DataIn <= SrIn & ~32'h2;
          end
        end
        StExcEpc: begin
          state_q   <= StExcSr;
          CP0Write  <= 1'b1;
          CP0RegIdx <= RegSr;
          CP0DataIn <= SrIn | 32'h2;
        end
        StExcSr: begin
          state_q    <= StExcJmp;
          PCRedirect <= 1'b1;
          RedirectPC <= HANDLER_VEC;
        end
        StEretSr: begin
          state_q    <= StEretJmp;
          PCRedirect <= 1'b1;
          RedirectPC <= EpcIn;
        end
        StExcJmp, StEretJmp: state_q <= StIdle;
        default:             state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed self-checking bench for exc_sequencer with hand-computed expectations.
module tb_exc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [5:0]  IntReq;
  logic        Syscall, RI, Overflow, EretReq;
  logic [31:0] ExcPC, SrIn, EpcIn;
  logic [31:0] CP0DataIn;
  logic [4:0]  CP0RegIdx;
  logic        CP0Write, Exception;
  logic [4:0]  Cause;
  logic        PCRedirect;
  logic [31:0] RedirectPC;
  logic        Stall;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  exc_sequencer #(
    .HANDLER_VEC(32'h0000_0080),
    .INT_W      (6)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .IntReq    (IntReq),
    .Syscall   (Syscall),
    .RI        (RI),
    .Overflow  (Overflow),
    .EretReq   (EretReq),
    .ExcPC     (ExcPC),
    .SrIn      (SrIn),
    .EpcIn     (EpcIn),
    .CP0DataIn (CP0DataIn),
    .CP0RegIdx (CP0RegIdx),
    .CP0Write  (CP0Write),
    .Exception (Exception),
    .Cause     (Cause),
    .PCRedirect(PCRedirect),
    .RedirectPC(RedirectPC),
    .Stall     (Stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_reqs();
    IntReq   = '0;
    Syscall  = 1'b0;
    RI       = 1'b0;
    Overflow = 1'b0;
    EretReq  = 1'b0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Request inputs must already be set; called half a cycle before the sampling edge.
  task automatic exc_seq(input string tag, input logic [4:0] code, input logic [31:0] pc,
                         input logic [31:0] sr_new);
    #1 check({tag, " stall_req"}, Stall, 1);
    step();
    check({tag, " epc_we"}, CP0Write, 1);
    check({tag, " epc_exc"}, Exception, 1);
    check({tag, " epc_idx"}, CP0RegIdx, 14);
    check({tag, " epc_data"}, CP0DataIn, pc);
    check({tag, " cause"}, Cause, code);
    clear_reqs();
    ExcPC = ~ExcPC;
    step();
    check({tag, " sr_we"}, CP0Write, 1);
    check({tag, " sr_exc"}, Exception, 0);
    check({tag, " sr_idx"}, CP0RegIdx, 12);
    check({tag, " sr_data"}, CP0DataIn, sr_new);
    check({tag, " sr_stall"}, Stall, 1);
    step();
    check({tag, " jmp_redir"}, PCRedirect, 1);
    check({tag, " jmp_pc"}, RedirectPC, 32'h80);
    check({tag, " jmp_we"}, CP0Write, 0);
    check({tag, " jmp_stall"}, Stall, 1);
    step();
    check({tag, " idle_redir"}, PCRedirect, 0);
    check({tag, " idle_stall"}, Stall, 0);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b0;
    clear_reqs();
    ExcPC = '0;
    SrIn  = '0;
    EpcIn = '0;
    #12;
    check("rst_we", CP0Write, 0);
    check("rst_exc", Exception, 0);
    check("rst_redir", PCRedirect, 0);
    check("rst_data", CP0DataIn, 0);
    check("rst_idx", CP0RegIdx, 0);
    check("rst_cause", Cause, 0);
    check("rst_rpc", RedirectPC, 0);
    check("rst_stall", Stall, 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    // Syscall entry
    Syscall = 1'b1; ExcPC = 32'h0000_1000; SrIn = 32'h1;
    exc_seq("sys", 5'd8, 32'h0000_1000, 32'h3);

    // Interrupt beats RI when enabled; masked by EXL leaves RI
    IntReq = 6'b000100; RI = 1'b1; SrIn = 32'h1; ExcPC = 32'h0000_2000;
    exc_seq("int", 5'd0, 32'h0000_2000, 32'h3);
    IntReq = 6'b000100; RI = 1'b1; SrIn = 32'h3; ExcPC = 32'h0000_3000;
    exc_seq("ri_exl", 5'd10, 32'h0000_3000, 32'h3);

    // RI > Overflow > Syscall
    RI = 1'b1; Overflow = 1'b1; Syscall = 1'b1; SrIn = 32'h0; ExcPC = 32'h0000_4000;
    exc_seq("pri_ri", 5'd10, 32'h0000_4000, 32'h2);
    Overflow = 1'b1; Syscall = 1'b1; SrIn = 32'h0; ExcPC = 32'h0000_4004;
    exc_seq("pri_ov", 5'd12, 32'h0000_4004, 32'h2);

    // Interrupt with IE=0 is ignored
    IntReq = 6'b000001; SrIn = 32'h0;
    #1 check("int_masked stall", Stall, 0);
    step();
    check("int_masked we", CP0Write, 0);
    check("int_masked stall2", Stall, 0);
    clear_reqs();
    @(negedge Clk);

    // ERET
    EretReq = 1'b1; SrIn = 32'h3; EpcIn = 32'h0000_2004;
    #1 check("eret stall_req", Stall, 1);
    step();
    check("eret sr_we", CP0Write, 1);
    check("eret sr_exc", Exception, 0);
    check("eret sr_idx", CP0RegIdx, 12);
    check("eret sr_data", CP0DataIn, 32'h1);
    clear_reqs();
    step();
    check("eret redir", PCRedirect, 1);
    check("eret rpc", RedirectPC, 32'h0000_2004);
    check("eret jmp_we", CP0Write, 0);
    step();
    check("eret idle_redir", PCRedirect, 0);
    check("eret idle_stall", Stall, 0);
    @(negedge Clk);

    // ERET loses to a simultaneous overflow
    EretReq = 1'b1; Overflow = 1'b1; SrIn = 32'h1; ExcPC = 32'h0000_5000;
    exc_seq("eret_ov", 5'd12, 32'h0000_5000, 32'h3);

    // Reset during EXC_SR aborts the sequence
    Syscall = 1'b1; SrIn = 32'h1; ExcPC = 32'h0000_6000;
    step();
    check("abort epc_we", CP0Write, 1);
    clear_reqs();
    step();
    check("abort sr_we", CP0Write, 1);
    Reset = 1'b0;
    #1;
    check("abort we", CP0Write, 0);
    check("abort data", CP0DataIn, 0);
    check("abort idx", CP0RegIdx, 0);
    check("abort stall", Stall, 0);
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort no_redir", PCRedirect, 0);
      check("abort no_we", CP0Write, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
